arcade_analog_emu: RTL and testbench

//  Multi-channel digital-to-analog control emulator: turns joystick/keyboard +/- buttons into

---
 rtl/arcade_analog_emu_if.sv | 24 ++
 rtl/arcade_analog_emu.sv | 148 ++++++++++++++
 tb/tb_arcade_analog_emu.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/arcade_analog_emu_if.sv
// Input-mux side bundle for arcade_analog_emu: frame sync, buttons, modes, analog samples
// and the resulting per-channel positions.
interface arcade_analog_emu_if #(
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned WIDTH    = 8
);
    logic                      vsync;
    logic [CHANNELS-1:0]       btn_plus;
    logic [CHANNELS-1:0]       btn_minus;
    logic [2*CHANNELS-1:0]     mode;
    logic [WIDTH*CHANNELS-1:0] analog_in;
    logic [WIDTH*CHANNELS-1:0] value_out;
    logic [CHANNELS-1:0]       moving;

    modport master (
        output vsync, btn_plus, btn_minus, mode, analog_in,
        input  value_out, moving
    );

    modport slave (
        input  vsync, btn_plus, btn_minus, mode, analog_in,
        output value_out, moving
    );
endinterface

// File: rtl/arcade_analog_emu.sv
// Per-frame button-to-analog position emulator: accelerated stepping with spring-return,
// hold, wrap (spinner) and direct analog passthrough per channel.
module arcade_analog_emu #(
    parameter int unsigned      CHANNELS     = 2,
    parameter int unsigned      WIDTH        = 8,
    parameter logic [WIDTH-1:0] CENTER       = 8'h80,
    parameter logic [WIDTH-1:0] VMIN         = 8'h00,
    parameter logic [WIDTH-1:0] VMAX         = 8'hFF,
    parameter int unsigned      STEP_BASE    = 2,
    parameter int unsigned      STEP_MAX     = 16,
    parameter int unsigned      ACCEL_FRAMES = 8,
    parameter int unsigned      RETURN_STEP  = 4
) (
    input logic                clk_sys,
    input logic                RESET,
    arcade_analog_emu_if.slave bus
);
    typedef enum logic [1:0] {
        M_SPRING = 2'b00,
        M_HOLD   = 2'b01,
        M_WRAP   = 2'b10,
        M_ANALOG = 2'b11
    } mode_e;

    // Two guard bits so VMAX+step and VMIN-step are both representable before clamping.
    localparam int unsigned AW = WIDTH + 2;
    localparam logic signed [AW-1:0] L_VMIN   = $signed({2'b00, VMIN});
    localparam logic signed [AW-1:0] L_VMAX   = $signed({2'b00, VMAX});
    localparam logic signed [AW-1:0] L_CENTER = $signed({2'b00, CENTER});
    localparam logic signed [AW-1:0] L_RET    = AW'(RETURN_STEP);
    localparam logic [AW-1:0]        L_BASE   = AW'(STEP_BASE);
    localparam logic [AW-1:0]        L_SMAX   = AW'(STEP_MAX);
    localparam logic [7:0]           L_ACCEL  = 8'(ACCEL_FRAMES);

    logic                r_vsync_d;
    logic                r_tick;
    logic [WIDTH-1:0]    r_val      [CHANNELS];
    logic [CHANNELS-1:0] r_moving;
    logic [AW-1:0]       r_step     [CHANNELS];
    logic [7:0]          r_cnt      [CHANNELS];
    logic [1:0]          r_dir_prev [CHANNELS];
    mode_e               r_mode_q   [CHANNELS];

    logic [1:0]          w_dir      [CHANNELS];
    mode_e               w_mode     [CHANNELS];
    logic [WIDTH-1:0]    w_analog   [CHANNELS];
    logic                w_fresh    [CHANNELS];
    logic [AW-1:0]       w_step_use [CHANNELS];
    logic [AW-1:0]       w_step_nxt [CHANNELS];
    logic [7:0]          w_cnt_nxt  [CHANNELS];
    logic signed [AW-1:0] w_cur     [CHANNELS];
    logic signed [AW-1:0] w_sum     [CHANNELS];
    logic signed [AW-1:0] w_dn      [CHANNELS];
    logic signed [AW-1:0] w_up      [CHANNELS];
    logic [WIDTH-1:0]    w_clamp    [CHANNELS];
    logic [WIDTH-1:0]    w_ret      [CHANNELS];
    logic [WIDTH-1:0]    w_val_nxt  [CHANNELS];

    always_comb begin
        for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
            // dir encoding: 01 = increase, 10 = decrease, 00 = none (both or neither pressed)
            w_dir[ch]    = {bus.btn_minus[ch] & ~bus.btn_plus[ch],
                            bus.btn_plus[ch]  & ~bus.btn_minus[ch]};
            w_mode[ch]   = mode_e'(bus.mode[2*ch +: 2]);
            w_analog[ch] = bus.analog_in[WIDTH*ch +: WIDTH];

            // A press that starts, reverses or follows a mode switch always moves by STEP_BASE.
            w_fresh[ch]    = (w_dir[ch] == 2'b00) || (w_dir[ch] != r_dir_prev[ch]) ||
                             (w_mode[ch] != r_mode_q[ch]);
            w_step_use[ch] = w_fresh[ch] ? L_BASE : r_step[ch];

            w_cnt_nxt[ch]  = '0;
            w_step_nxt[ch] = L_BASE;
            if (!w_fresh[ch]) begin
                if (r_cnt[ch] + 8'd1 >= L_ACCEL) begin
                    w_step_nxt[ch] = ((r_step[ch] << 1) > L_SMAX) ? L_SMAX : (r_step[ch] << 1);
                end else begin
                    w_cnt_nxt[ch]  = r_cnt[ch] + 8'd1;
                    w_step_nxt[ch] = r_step[ch];
                end
            end

            w_cur[ch] = $signed({2'b00, r_val[ch]});
            w_sum[ch] = w_dir[ch][0] ? w_cur[ch] + $signed(w_step_use[ch])
                                     : w_cur[ch] - $signed(w_step_use[ch]);
            w_clamp[ch] = (w_sum[ch] < L_VMIN) ? VMIN :
                          (w_sum[ch] > L_VMAX) ? VMAX : w_sum[ch][WIDTH-1:0];

            w_dn[ch] = w_cur[ch] - L_RET;
            w_up[ch] = w_cur[ch] + L_RET;
            if (w_cur[ch] > L_CENTER) begin
                w_ret[ch] = (w_dn[ch] < L_CENTER) ? CENTER : w_dn[ch][WIDTH-1:0];
            end else begin
                w_ret[ch] = (w_up[ch] > L_CENTER) ? CENTER : w_up[ch][WIDTH-1:0];
            end

            case (w_mode[ch])
                M_SPRING: w_val_nxt[ch] = (w_dir[ch] != 2'b00) ? w_clamp[ch] : w_ret[ch];
                M_HOLD:   w_val_nxt[ch] = (w_dir[ch] != 2'b00) ? w_clamp[ch] : r_val[ch];
                M_WRAP:   w_val_nxt[ch] = (w_dir[ch] != 2'b00) ? w_sum[ch][WIDTH-1:0] : r_val[ch];
                default:  w_val_nxt[ch] = w_analog[ch];
            endcase
        end
    end

    always_ff @(posedge clk_sys) begin
        if (RESET) begin
            r_vsync_d <= 1'b0;
            r_tick    <= 1'b0;
            r_moving  <= '0;
            for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
                r_val[ch]      <= CENTER;
                r_step[ch]     <= L_BASE;
                r_cnt[ch]      <= '0;
                r_dir_prev[ch] <= '0;
                r_mode_q[ch]   <= M_SPRING;
            end
        end else begin
            r_vsync_d <= bus.vsync;
            r_tick    <= bus.vsync & ~r_vsync_d;
            for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
                r_mode_q[ch] <= w_mode[ch];
                if (w_mode[ch] == M_ANALOG || r_tick) begin
                    r_val[ch]    <= w_val_nxt[ch];
                    r_moving[ch] <= (w_val_nxt[ch] != r_val[ch]);
                end
                if (w_mode[ch] == M_ANALOG || (!r_tick && w_mode[ch] != r_mode_q[ch])) begin
                    r_step[ch]     <= L_BASE;
                    r_cnt[ch]      <= '0;
                    r_dir_prev[ch] <= '0;
                end else if (r_tick) begin
                    r_step[ch]     <= w_step_nxt[ch];
                    r_cnt[ch]      <= w_cnt_nxt[ch];
                    r_dir_prev[ch] <= w_dir[ch];
                end
            end
        end
    end

    always_comb begin
        bus.value_out = '0;
        for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
            bus.value_out[WIDTH*ch +: WIDTH] = r_val[ch];
        end
    end

    assign bus.moving = r_moving;
endmodule

// File: tb/tb_arcade_analog_emu.sv
// Bench for arcade_analog_emu: directed scenarios plus randomized frames, checked against
// a frame-level integer model of the position rules.
module tb_arcade_analog_emu;
    localparam int CH   = 2;
    localparam int W    = 8;
    localparam int BASE = 2;
    localparam int SMAX = 16;
    localparam int ACC  = 8;
    localparam int RET  = 4;
    localparam int CTR  = 'h80;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    arcade_analog_emu_if #(.CHANNELS(CH), .WIDTH(W)) bus ();

    arcade_analog_emu #(
        .CHANNELS(CH), .WIDTH(W), .CENTER(8'h80), .VMIN(8'h00), .VMAX(8'hFF),
        .STEP_BASE(BASE), .STEP_MAX(SMAX), .ACCEL_FRAMES(ACC), .RETURN_STEP(RET)
    ) dut (
        .clk_sys(clk),
        .RESET  (rst),
        .bus    (bus)
    );

    int total = 0;
    int bad   = 0;

    int in_plus [CH];
    int in_minus[CH];
    int in_mode [CH];
    int in_ana  [CH];

    // model state: position, current step, held-frame count, last direction, moving flag
    int m_val [CH];
    int m_step[CH];
    int m_cnt [CH];
    int m_dir [CH];
    int m_mov [CH];

    task automatic check_eq(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int dut_val(input int ch);
        return int'(bus.value_out[W*ch +: W]);
    endfunction

    function automatic int dut_mov(input int ch);
        return int'(bus.moving[ch]);
    endfunction

    task automatic drive();
        for (int ch = 0; ch < CH; ch++) begin
            bus.btn_plus[ch]           = (in_plus[ch] != 0);
            bus.btn_minus[ch]          = (in_minus[ch] != 0);
            bus.mode[2*ch +: 2]        = 2'(in_mode[ch]);
            bus.analog_in[W*ch +: W]   = 8'(in_ana[ch]);
        end
    endtask

    task automatic set_ch(input int ch, input int mode, input int p, input int m, input int a);
        if (mode != in_mode[ch]) begin
            m_step[ch] = BASE;
            m_cnt[ch]  = 0;
            m_dir[ch]  = 0;
        end
        in_mode[ch]  = mode;
        in_plus[ch]  = p;
        in_minus[ch] = m;
        in_ana[ch]   = a;
        drive();
    endtask

    task automatic model_reset();
        for (int ch = 0; ch < CH; ch++) begin
            m_val[ch]  = CTR;
            m_step[ch] = BASE;
            m_cnt[ch]  = 0;
            m_dir[ch]  = 0;
            m_mov[ch]  = 0;
        end
    endtask

    task automatic model_tick();
        int dir, use_step, nv, old;
        for (int ch = 0; ch < CH; ch++) begin
            if (in_mode[ch] == 3) begin
                m_val[ch] = in_ana[ch];
                m_mov[ch] = 0;
                continue;
            end
            dir = (in_plus[ch] != 0 && in_minus[ch] == 0) ? 1 :
                  (in_minus[ch] != 0 && in_plus[ch] == 0) ? -1 : 0;
            if (dir == 0 || dir != m_dir[ch]) begin
                m_step[ch] = BASE;
                m_cnt[ch]  = 0;
                use_step   = BASE;
            end else begin
                use_step = m_step[ch];
                m_cnt[ch]++;
                if (m_cnt[ch] == ACC) begin
                    m_cnt[ch]  = 0;
                    m_step[ch] = (2 * m_step[ch] > SMAX) ? SMAX : 2 * m_step[ch];
                end
            end
            m_dir[ch] = dir;
            old = m_val[ch];
            if (in_mode[ch] == 2)      nv = (old + dir * use_step + 256) % 256;
            else if (dir != 0) begin
                nv = old + dir * use_step;
                if (nv < 0)   nv = 0;
                if (nv > 255) nv = 255;
            end
            else if (in_mode[ch] == 1) nv = old;
            else if (old > CTR)        nv = (old - RET < CTR) ? CTR : old - RET;
            else                       nv = (old + RET > CTR) ? CTR : old + RET;
            m_mov[ch] = (nv != old) ? 1 : 0;
            m_val[ch] = nv;
        end
    endtask

    task automatic check_all(input string tag);
        for (int ch = 0; ch < CH; ch++) begin
            check_eq($sformatf("%s_val%0d", tag, ch), dut_val(ch), m_val[ch]);
            check_eq($sformatf("%s_mov%0d", tag, ch), dut_mov(ch), m_mov[ch]);
        end
    endtask

    task automatic do_frame(input string tag);
        bus.vsync = 1'b1;
        @(negedge clk);
        bus.vsync = 1'b0;
        repeat (3) @(negedge clk);
        model_tick();
        check_all(tag);
    endtask

    // Loads a position through ANALOG mode and checks the one-cycle passthrough latency.
    task automatic analog_load(input int ch, input int v);
        int exp_mov;
        exp_mov = (v != m_val[ch]) ? 1 : 0;
        set_ch(ch, 3, 0, 0, v);
        @(negedge clk);
        check_eq("ana_lat_val", dut_val(ch), v);
        check_eq("ana_lat_mov", dut_mov(ch), exp_mov);
        @(negedge clk);
        m_val[ch] = v;
        m_mov[ch] = 0;
        check_eq("ana_settle_mov", dut_mov(ch), 0);
    endtask

    initial begin
        bus.vsync = 1'b0;
        for (int ch = 0; ch < CH; ch++) begin
            in_plus[ch] = 0; in_minus[ch] = 0; in_mode[ch] = 0; in_ana[ch] = 0;
        end
        drive();
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_all("reset");

        // spring: press plus three frames, then release and return without overshoot
        set_ch(0, 0, 1, 0, 0);
        repeat (3) do_frame("spr_up");
        check_eq("spr_86", dut_val(0), 'h86);
        set_ch(0, 0, 0, 0, 0);
        do_frame("spr_ret");
        check_eq("spr_82", dut_val(0), 'h82);
        repeat (2) do_frame("spr_ret");
        check_eq("spr_80", dut_val(0), 'h80);

        // hold: minus accelerates, then saturates at VMIN
        set_ch(0, 1, 0, 1, 0);
        repeat (9) do_frame("hold_dn");
        check_eq("hold_6e", dut_val(0), 'h6E);
        do_frame("hold_dn");
        check_eq("hold_6a", dut_val(0), 'h6A);
        repeat (20) do_frame("hold_sat");
        check_eq("hold_min", dut_val(0), 'h00);
        check_eq("hold_min_mov", dut_mov(0), 0);

        // wrap both directions
        analog_load(0, 'hFE);
        set_ch(0, 2, 1, 0, 0);
        do_frame("wrap_up");
        check_eq("wrap_00", dut_val(0), 'h00);
        analog_load(0, 'h01);
        set_ch(0, 2, 0, 1, 0);
        do_frame("wrap_dn");
        check_eq("wrap_ff", dut_val(0), 'hFF);

        // both buttons: spring returns, hold stays
        analog_load(0, 'h90);
        set_ch(0, 0, 1, 1, 0);
        do_frame("both_spr");
        check_eq("both_8c", dut_val(0), 'h8C);
        repeat (3) do_frame("both_spr");
        check_eq("both_80", dut_val(0), 'h80);
        analog_load(0, 'h90);
        set_ch(0, 1, 1, 1, 0);
        do_frame("both_hold");
        check_eq("both_90", dut_val(0), 'h90);

        // analog passthrough then hold continues from the sample
        analog_load(0, 'h3C);
        set_ch(0, 1, 1, 0, 0);
        do_frame("ana_hold");
        check_eq("ana_3e", dut_val(0), 'h3E);

        // reset landing on the tick cycle wins over the update
        analog_load(0, 'h40);
        set_ch(0, 1, 1, 0, 0);
        bus.vsync = 1'b1;
        @(negedge clk);
        bus.vsync = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check_eq("rst_tick_val", dut_val(0), 'h80);
        check_eq("rst_tick_mov", dut_mov(0), 0);
        repeat (2) @(negedge clk);
        do_frame("rst_step");
        check_eq("rst_82", dut_val(0), 'h82);

        // randomized frames across all modes and channels
        for (int f = 0; f < 300; f++) begin
            for (int ch = 0; ch < CH; ch++) begin
                int md, p, m;
                md = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : in_mode[ch];
                p  = in_plus[ch];
                m  = in_minus[ch];
                if ($urandom_range(0, 3) == 0) begin
                    p = int'($urandom_range(0, 1));
                    m = int'($urandom_range(0, 1));
                end
                set_ch(ch, md, p, m, int'($urandom_range(0, 255)));
            end
            do_frame($sformatf("rnd%0d", f));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
